// File: rtl/mole_lifetime_tracker.sv
// mole_lifetime_tracker
// Per-hole mole lifetime manager: spawns moles, times them out on game ticks,
// retires them on strikes, and blocks each hole for a cooldown before reuse.
// Emits the live mole vector plus registered hit/miss/escape events and a
// saturating escape counter.
module mole_lifetime_tracker #(
  parameter int NUM_HOLES      = 5,
  parameter int LIFETIME_TICKS = 3,
  parameter int COOLDOWN_TICKS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 tick,
  input  logic                 spawn_valid,
  input  logic [NUM_HOLES-1:0] spawn,
  input  logic [2:0]           hit_hole,
  output logic [NUM_HOLES-1:0] moles_up,
  output logic                 hit_pulse,
  output logic [2:0]           hit_index,
  output logic                 miss_pulse,
  output logic                 escape_pulse,
  output logic [7:0]           escape_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    UP    = 2'd1,
    COOL  = 2'd2
  } hole_state_t;

  localparam logic [3:0] LIFE_LOAD = 4'(LIFETIME_TICKS);
  localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_TICKS);

  hole_state_t          state_r [NUM_HOLES];
  hole_state_t          state_s [NUM_HOLES];
  logic [3:0]           cnt_r   [NUM_HOLES];
  logic [3:0]           cnt_s   [NUM_HOLES];
  logic [2:0]           prev_hit_r;
  logic                 strike_s;
  logic [NUM_HOLES-1:0] hit_sel_s;
  logic [NUM_HOLES-1:0] up_vec_s;
  logic [NUM_HOLES-1:0] escape_s;
  logic [NUM_HOLES-1:0] up_next_s;
  logic                 hit_any_s;
  logic                 miss_any_s;

  logic [NUM_HOLES-1:0] moles_up_r;
  logic                 hit_pulse_r;
  logic [2:0]           hit_index_r;
  logic                 miss_pulse_r;
  logic                 escape_pulse_r;
  logic [7:0]           escape_count_r;

  // Strike decode: a new in-range switch value differing from last cycle's.
  always_comb begin
    strike_s  = 1'b0;
    hit_sel_s = '0;
    up_vec_s  = '0;
    if ((hit_hole != 3'd0) && (hit_hole <= 3'(NUM_HOLES)) && (hit_hole != prev_hit_r)) begin
      strike_s = 1'b1;
    end else begin
      strike_s = 1'b0;
    end
    for (int i = 0; i < NUM_HOLES; i++) begin
      hit_sel_s[i] = strike_s && (hit_hole == 3'(i + 1));
      up_vec_s[i]  = (state_r[i] == UP);
    end
    hit_any_s  = |(hit_sel_s & up_vec_s);
    miss_any_s = strike_s && !hit_any_s;
  end

  // Per-hole next-state and tick counter update.
  always_comb begin
    escape_s  = '0;
    up_next_s = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      case (state_r[i])
        EMPTY: begin
          if (spawn_valid && spawn[i]) begin
            state_s[i] = UP;
            cnt_s[i]   = LIFE_LOAD;
          end else begin
            state_s[i] = EMPTY;
          end
        end
        UP: begin
          if (hit_sel_s[i]) begin
            // Strike beats an expiring tick in the same cycle.
            state_s[i] = COOL;
            cnt_s[i]   = COOL_LOAD;
          end else if (tick) begin
            if (cnt_r[i] == 4'd1) begin
              state_s[i]  = COOL;
              cnt_s[i]    = COOL_LOAD;
              escape_s[i] = 1'b1;
            end else begin
              cnt_s[i] = cnt_r[i] - 4'd1;
            end
          end else begin
            state_s[i] = UP;
          end
        end
        COOL: begin
          if (COOL_LOAD == 4'd0) begin
            state_s[i] = EMPTY;
            cnt_s[i]   = 4'd0;
          end else if (tick) begin
            if (cnt_r[i] == 4'd1) begin
              state_s[i] = EMPTY;
              cnt_s[i]   = 4'd0;
            end else begin
              cnt_s[i] = cnt_r[i] - 4'd1;
            end
          end else begin
            state_s[i] = COOL;
          end
        end
        default: begin
          state_s[i] = EMPTY;
          cnt_s[i]   = 4'd0;
        end
      endcase
      up_next_s[i] = (state_s[i] == UP);
    end
  end

  // State, counters, event pulses and escape counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOLES; i++) begin
        state_r[i] <= EMPTY;
        cnt_r[i]   <= 4'd0;
      end
      prev_hit_r     <= 3'd0;
      moles_up_r     <= '0;
      hit_pulse_r    <= 1'b0;
      hit_index_r    <= 3'd0;
      miss_pulse_r   <= 1'b0;
      escape_pulse_r <= 1'b0;
      escape_count_r <= 8'd0;
    end else if (clear) begin
      for (int i = 0; i < NUM_HOLES; i++) begin
        state_r[i] <= EMPTY;
        cnt_r[i]   <= 4'd0;
      end
      prev_hit_r     <= 3'd0;
      moles_up_r     <= '0;
      hit_pulse_r    <= 1'b0;
      hit_index_r    <= 3'd0;
      miss_pulse_r   <= 1'b0;
      escape_pulse_r <= 1'b0;
      escape_count_r <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_HOLES; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      prev_hit_r     <= hit_hole;
      moles_up_r     <= up_next_s;
      hit_pulse_r    <= hit_any_s;
      miss_pulse_r   <= miss_any_s;
      escape_pulse_r <= |escape_s;
      if (strike_s) begin
        hit_index_r <= hit_hole;
      end else begin
        hit_index_r <= hit_index_r;
      end
      if ((|escape_s) && (escape_count_r != 8'd255)) begin
        escape_count_r <= escape_count_r + 8'd1;
      end else begin
        escape_count_r <= escape_count_r;
      end
    end
  end

  assign moles_up     = moles_up_r;
  assign hit_pulse    = hit_pulse_r;
  assign hit_index    = hit_index_r;
  assign miss_pulse   = miss_pulse_r;
  assign escape_pulse = escape_pulse_r;
  assign escape_count = escape_count_r;

endmodule

// File: tb/tb_mole_lifetime_tracker.sv
// Directed self-checking bench for mole_lifetime_tracker (default parameters).
module tb_mole_lifetime_tracker;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       tick;
  logic       spawn_valid;
  logic [4:0] spawn;
  logic [2:0] hit_hole;
  logic [4:0] moles_up;
  logic       hit_pulse;
  logic [2:0] hit_index;
  logic       miss_pulse;
  logic       escape_pulse;
  logic [7:0] escape_count;

  int checks;
  int errors;
  int hits_seen;
  int misses_seen;
  int exp_count;

  mole_lifetime_tracker dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .tick         (tick),
    .spawn_valid  (spawn_valid),
    .spawn        (spawn),
    .hit_hole     (hit_hole),
    .moles_up     (moles_up),
    .hit_pulse    (hit_pulse),
    .hit_index    (hit_index),
    .miss_pulse   (miss_pulse),
    .escape_pulse (escape_pulse),
    .escape_count (escape_count)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".moles"}, 32'(moles_up), 32'd0);
    chk({tag, ".hit"}, 32'(hit_pulse), 32'd0);
    chk({tag, ".miss"}, 32'(miss_pulse), 32'd0);
    chk({tag, ".esc"}, 32'(escape_pulse), 32'd0);
    chk({tag, ".idx"}, 32'(hit_index), 32'd0);
    chk({tag, ".cnt"}, 32'(escape_count), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; clear = 1'b0; tick = 1'b0;
    spawn_valid = 1'b0; spawn = 5'd0; hit_hole = 3'd0;
    #23;
    chk_idle("reset");
    reset = 1'b0;
    cyc();

    // Spawn hole 2, then three ticks time it out.
    spawn_valid = 1'b1; spawn = 5'b00100;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    chk("spawn.moles", 32'(moles_up), 32'h04);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tick1.moles", 32'(moles_up), 32'h04);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tick2.esc", 32'(escape_pulse), 32'd0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tick3.moles", 32'(moles_up), 32'd0);
    chk("tick3.esc", 32'(escape_pulse), 32'd1);
    chk("tick3.cnt", 32'(escape_count), 32'd1);
    // Spawn during cooldown is dropped.
    spawn_valid = 1'b1; spawn = 5'b00100;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    chk("esc.onecycle", 32'(escape_pulse), 32'd0);
    chk("cool.drop", 32'(moles_up), 32'd0);
    tick = 1'b1; cyc(); tick = 1'b0;
    spawn_valid = 1'b1; spawn = 5'b00100;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    chk("respawn.moles", 32'(moles_up), 32'h04);

    // Held switch on hole 2 yields exactly one hit.
    hits_seen = 0; misses_seen = 0;
    hit_hole = 3'd3;
    cyc();
    chk("hit.pulse", 32'(hit_pulse), 32'd1);
    chk("hit.index", 32'(hit_index), 32'd3);
    chk("hit.moles", 32'(moles_up), 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (hit_pulse) hits_seen++;
      if (miss_pulse) misses_seen++;
      cyc();
    end
    chk("held.hits", 32'(hits_seen), 32'd1);
    chk("held.misses", 32'(misses_seen), 32'd0);
    chk("held.index", 32'(hit_index), 32'd3);
    hit_hole = 3'd0;
    tick = 1'b1; cyc(); tick = 1'b0;

    // Miss on empty hole 0 with spawn same cycle: miss, spawn accepted.
    hit_hole = 3'd1; spawn_valid = 1'b1; spawn = 5'b00001;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    chk("miss.pulse", 32'(miss_pulse), 32'd1);
    chk("miss.hit", 32'(hit_pulse), 32'd0);
    chk("miss.spawn", 32'(moles_up), 32'h01);
    cyc();
    chk("miss.onecycle", 32'(miss_pulse), 32'd0);
    hit_hole = 3'd0;

    // Tick + spawn on hole 1: full lifetime loaded, hole 0 ages.
    tick = 1'b1; spawn_valid = 1'b1; spawn = 5'b00010;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    chk("tickspawn.moles", 32'(moles_up), 32'h03);
    cyc();
    chk("age1.moles", 32'(moles_up), 32'h03);
    cyc();
    chk("age2.moles", 32'(moles_up), 32'h02);
    chk("age2.esc", 32'(escape_pulse), 32'd1);
    chk("age2.cnt", 32'(escape_count), 32'd2);
    cyc();
    chk("age3.moles", 32'(moles_up), 32'h00);
    chk("age3.cnt", 32'(escape_count), 32'd3);
    cyc();
    tick = 1'b0;

    // Race on hole 4: strike and expiring tick together -> hit wins.
    spawn_valid = 1'b1; spawn = 5'b10000;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    tick = 1'b1; cyc(); cyc();
    hit_hole = 3'd5;
    cyc();
    tick = 1'b0;
    chk("race.hit", 32'(hit_pulse), 32'd1);
    chk("race.esc", 32'(escape_pulse), 32'd0);
    chk("race.cnt", 32'(escape_count), 32'd3);
    chk("race.index", 32'(hit_index), 32'd5);
    hit_hole = 3'd0;
    tick = 1'b1; cyc(); tick = 1'b0;

    // 260 escape cycles; counter saturates at 255.
    exp_count = 3;
    for (int k = 0; k < 260; k++) begin
      spawn_valid = 1'b1; spawn = 5'b11111;
      cyc();
      spawn_valid = 1'b0; spawn = 5'd0;
      tick = 1'b1;
      cyc(); cyc(); cyc();
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      if (k % 16 == 0 || k >= 250) begin
        chk("sat.cnt", 32'(escape_count), 32'(exp_count));
      end
      cyc();
      tick = 1'b0;
    end
    chk("sat.final", 32'(escape_count), 32'd255);

    // Clear (with a tick in the same cycle) wipes everything.
    spawn_valid = 1'b1; spawn = 5'b11111;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    chk("preclear.moles", 32'(moles_up), 32'h1f);
    clear = 1'b1; tick = 1'b1;
    cyc();
    clear = 1'b0; tick = 1'b0;
    chk("clear.cnt", 32'(escape_count), 32'd0);
    chk("clear.moles", 32'(moles_up), 32'd0);
    chk("clear.idx", 32'(hit_index), 32'd0);

    // Async reset with a hit pulse in flight.
    spawn_valid = 1'b1; spawn = 5'b00011;
    cyc();
    spawn_valid = 1'b0; spawn = 5'd0;
    hit_hole = 3'd1; tick = 1'b1;
    cyc();
    chk("inflight.hit", 32'(hit_pulse), 32'd1);
    chk("inflight.moles", 32'(moles_up), 32'h02);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("asyncrst");
    hit_hole = 3'd0; tick = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk_idle("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
